// File: rtl/inference_request_pipeline_scheduler.sv
// Whole-packet round-robin scheduler feeding N AXI-Stream request sources into one
// inference pipeline, with admission limited by in-flight packet credits.
module inference_request_pipeline_scheduler #(
   parameter int  NUM_REQUESTERS = 4,
   parameter int  TDATA_WIDTH    = 256,
   parameter int  TUSER_WIDTH    = 128,
   parameter int  MAX_IN_FLIGHT  = 2,
   parameter int  SRC_ID_LSB     = 120,
   localparam int TKEEP_WIDTH    = TDATA_WIDTH / 8,
   localparam int CNT_W          = $clog2(MAX_IN_FLIGHT + 1),
   localparam int ID_W           = 3
) (
   input  logic                                  axis_aclk,
   input  logic                                  axis_resetn,
   input  logic [NUM_REQUESTERS*TDATA_WIDTH-1:0] s_axis_tdata,
   input  logic [NUM_REQUESTERS*TKEEP_WIDTH-1:0] s_axis_tkeep,
   input  logic [NUM_REQUESTERS*TUSER_WIDTH-1:0] s_axis_tuser,
   input  logic [NUM_REQUESTERS-1:0]             s_axis_tvalid,
   output logic [NUM_REQUESTERS-1:0]             s_axis_tready,
   input  logic [NUM_REQUESTERS-1:0]             s_axis_tlast,
   output logic [TDATA_WIDTH-1:0]                m_axis_tdata,
   output logic [TKEEP_WIDTH-1:0]                m_axis_tkeep,
   output logic [TUSER_WIDTH-1:0]                m_axis_tuser,
   output logic                                  m_axis_tvalid,
   input  logic                                  m_axis_tready,
   output logic                                  m_axis_tlast,
   input  logic                                  done_tvalid,
   input  logic                                  done_tready,
   input  logic                                  done_tlast,
   output logic [CNT_W-1:0]                      in_flight,
   output logic [ID_W-1:0]                       grant_id,
   output logic                                  busy,
   output logic                                  credit_err
);

   typedef enum logic {S_IDLE, S_PASS} state_t;

   state_t            state_q;
   logic [ID_W-1:0]   grant_q;
   logic [ID_W-1:0]   rr_ptr_q;
   logic [CNT_W-1:0]  in_flight_q, in_flight_d;
   logic              busy_q;
   logic              credit_err_q;

   logic              arb_found;
   logic [ID_W-1:0]   arb_pick;
   logic [ID_W:0]     cand;

   logic [TDATA_WIDTH-1:0] mux_data;
   logic [TKEEP_WIDTH-1:0] mux_keep;
   logic [TUSER_WIDTH-1:0] mux_user, user_tagged;
   logic                   mux_valid, mux_last;

   logic pass, admit, completion, pkt_end;

   assign pass = (state_q == S_PASS);

   // Rotating search starting just after the last winner; cand never exceeds 2N-1.
   always_comb begin
      arb_found = 1'b0;
      arb_pick  = '0;
      cand      = '0;
      for (int k = 1; k <= NUM_REQUESTERS; k++) begin
         cand = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
         if (cand >= (ID_W+1)'(NUM_REQUESTERS))
            cand = cand - (ID_W+1)'(NUM_REQUESTERS);
         for (int i = 0; i < NUM_REQUESTERS; i++) begin
            if (!arb_found && cand == (ID_W+1)'(i) && s_axis_tvalid[i]) begin
               arb_found = 1'b1;
               arb_pick  = ID_W'(i);
            end
         end
      end
   end

   always_comb begin
      mux_data  = '0;
      mux_keep  = '0;
      mux_user  = '0;
      mux_valid = 1'b0;
      mux_last  = 1'b0;
      for (int i = 0; i < NUM_REQUESTERS; i++) begin
         if (grant_q == ID_W'(i)) begin
            mux_data  = s_axis_tdata[i*TDATA_WIDTH +: TDATA_WIDTH];
            mux_keep  = s_axis_tkeep[i*TKEEP_WIDTH +: TKEEP_WIDTH];
            mux_user  = s_axis_tuser[i*TUSER_WIDTH +: TUSER_WIDTH];
            mux_valid = s_axis_tvalid[i];
            mux_last  = s_axis_tlast[i];
         end
      end
   end

   // Pipeline learns which source a packet came from through the tuser id field.
   always_comb begin
      user_tagged                          = mux_user;
      user_tagged[SRC_ID_LSB +: ID_W]      = grant_q;
   end

   always_comb begin
      s_axis_tready = '0;
      for (int i = 0; i < NUM_REQUESTERS; i++)
         s_axis_tready[i] = pass && (grant_q == ID_W'(i)) && m_axis_tready;
   end

   assign m_axis_tvalid = pass & mux_valid;
   assign m_axis_tlast  = pass & mux_last;
   assign m_axis_tdata  = pass ? mux_data    : '0;
   assign m_axis_tkeep  = pass ? mux_keep    : '0;
   assign m_axis_tuser  = pass ? user_tagged : '0;

   assign admit      = (state_q == S_IDLE) && (in_flight_q < CNT_W'(MAX_IN_FLIGHT)) && arb_found;
   assign completion = done_tvalid & done_tready & done_tlast;
   assign pkt_end    = m_axis_tvalid & m_axis_tready & m_axis_tlast;

   // A completion with nothing outstanding is an error, not an underflow.
   always_comb begin
      in_flight_d = in_flight_q;
      if (admit && !completion)
         in_flight_d = in_flight_q + CNT_W'(1);
      else if (!admit && completion && in_flight_q != '0)
         in_flight_d = in_flight_q - CNT_W'(1);
   end

   always_ff @(posedge axis_aclk or negedge axis_resetn) begin
      if (!axis_resetn) begin
         state_q      <= S_IDLE;
         grant_q      <= '0;
         rr_ptr_q     <= ID_W'(NUM_REQUESTERS - 1);
         in_flight_q  <= '0;
         busy_q       <= 1'b0;
         credit_err_q <= 1'b0;
      end else begin
         in_flight_q <= in_flight_d;
         if (completion && in_flight_q == '0)
            credit_err_q <= 1'b1;
         case (state_q)
            S_IDLE: begin
               if (admit) begin
                  state_q  <= S_PASS;
                  grant_q  <= arb_pick;
                  rr_ptr_q <= arb_pick;
                  busy_q   <= 1'b1;
               end
            end
            S_PASS: begin
               if (pkt_end) begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign in_flight  = in_flight_q;
   assign grant_id   = grant_q;
   assign busy       = busy_q;
   assign credit_err = credit_err_q;

endmodule

// File: tb/tb_inference_request_pipeline_scheduler.sv
// Scoreboard bench: per-source beat stores feed the scheduler, expected beats are
// queued in predicted grant order and compared as they leave m_axis.
module tb_inference_request_pipeline_scheduler;
   localparam int N  = 4;
   localparam int DW = 256;
   localparam int KW = 32;
   localparam int UW = 128;

   typedef struct packed {
      logic [2:0]  src;
      logic [31:0] tag;
      logic        last;
   } beat_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [N*DW-1:0] s_tdata;
   logic [N*KW-1:0] s_tkeep;
   logic [N*UW-1:0] s_tuser;
   logic [N-1:0]    s_tvalid, s_tready, s_tlast;
   logic [DW-1:0]   m_tdata;
   logic [KW-1:0]   m_tkeep;
   logic [UW-1:0]   m_tuser;
   logic            m_tvalid, m_tlast;
   logic            m_tready = 1'b1;
   logic            d_valid, d_ready, d_last;
   logic [1:0]      in_flight;
   logic [2:0]      grant_id;
   logic            busy, credit_err;

   logic            auto_done = 1'b0;
   logic            man_done  = 1'b0;
   logic            rand_rdy  = 1'b0;
   logic [N-1:0]    bubble    = '0;

   beat_t src_mem [N][16];
   int    src_hd [N];
   int    src_tl [N];
   beat_t exp_q [$];
   beat_t drv_b;

   int vectors = 0;
   int errs    = 0;

   always #5 clk = ~clk;

   // auto_done models a zero-latency pipeline that completes each packet as it is accepted
   assign d_valid = auto_done ? (m_tvalid & m_tready & m_tlast) : man_done;
   assign d_ready = 1'b1;
   assign d_last  = 1'b1;

   inference_request_pipeline_scheduler #(
      .NUM_REQUESTERS(N), .TDATA_WIDTH(DW), .TUSER_WIDTH(UW),
      .MAX_IN_FLIGHT(2), .SRC_ID_LSB(120)
   ) dut (
      .axis_aclk(clk), .axis_resetn(rst_n),
      .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tuser(s_tuser),
      .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tlast(s_tlast),
      .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tuser(m_tuser),
      .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tlast(m_tlast),
      .done_tvalid(d_valid), .done_tready(d_ready), .done_tlast(d_last),
      .in_flight(in_flight), .grant_id(grant_id), .busy(busy), .credit_err(credit_err)
   );

   function automatic logic [UW-1:0] src_user(input beat_t b);
      return {4{b.tag ^ 32'h5A5A_F00F}};
   endfunction

   function automatic logic [UW-1:0] exp_user(input beat_t b);
      logic [UW-1:0] u;
      u = src_user(b);
      u[122:120] = b.src;
      return u;
   endfunction

   always_comb begin
      s_tvalid = '0; s_tdata = '0; s_tkeep = '0; s_tuser = '0; s_tlast = '0;
      drv_b = '0;
      for (int i = 0; i < N; i++) begin
         if (src_hd[i] < src_tl[i]) begin
            drv_b = src_mem[i][4'(src_hd[i])];
            s_tvalid[i]           = ~bubble[i];
            s_tdata[i*DW +: DW]   = {8{drv_b.tag}};
            s_tkeep[i*KW +: KW]   = drv_b.tag;
            s_tuser[i*UW +: UW]   = src_user(drv_b);
            s_tlast[i]            = drv_b.last;
         end
      end
   end

   task automatic send_pkt(input int src, input int n, input logic [31:0] tag);
      beat_t b;
      for (int k = 0; k < n; k++) begin
         b = '{src: 3'(src), tag: tag + 32'(k), last: (k == n - 1)};
         src_mem[src][4'(src_tl[src])] = b;
         src_tl[src]++;
      end
   endtask

   task automatic expect_pkt(input int src, input int n, input logic [31:0] tag);
      for (int k = 0; k < n; k++)
         exp_q.push_back('{src: 3'(src), tag: tag + 32'(k), last: (k == n - 1)});
   endtask

   // One clock: score any beat about to transfer, then retire accepted source beats.
   task automatic step();
      logic [N-1:0] popm;
      beat_t e;
      @(negedge clk);
      popm = s_tready & s_tvalid;
      if (m_tvalid && m_tready) begin
         vectors++;
         if (exp_q.size() == 0) begin
            errs++;
            $display("FAIL beat_unexpected: got tag %h, required no beat", m_tdata[31:0]);
         end else begin
            e = exp_q.pop_front();
            if (m_tdata !== {8{e.tag}} || m_tkeep !== e.tag || m_tuser !== exp_user(e) ||
                m_tlast !== e.last) begin
               errs++;
               $display("FAIL beat: got tag %h id %0d last %b, required tag %h id %0d last %b",
                        m_tdata[31:0], m_tuser[122:120], m_tlast, e.tag, e.src, e.last);
            end
         end
      end
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) if (popm[i]) src_hd[i]++;
      if (rand_rdy) begin
         m_tready  = 1'($urandom_range(0, 1));
         bubble[3] = ($urandom_range(0, 3) == 0);
      end
   endtask

   task automatic wait_drain(input int budget, input int left);
      int n = 0;
      while (exp_q.size() > left && n < budget) begin
         step();
         n++;
      end
      vectors++;
      if (exp_q.size() > left) begin
         errs++;
         $display("FAIL drain_timeout: got %0d beats pending, required %0d", exp_q.size(), left);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      m_tready = 1'b1; auto_done = 1'b0; man_done = 1'b0; rand_rdy = 1'b0; bubble = '0;
      exp_q.delete();
      for (int i = 0; i < N; i++) begin src_hd[i] = 0; src_tl[i] = 0; end
      #1;
      vectors++;
      if (m_tvalid !== 1'b0 || s_tready !== 4'b0 || m_tdata !== '0 || m_tlast !== 1'b0) begin
         errs++;
         $display("FAIL reset_ports: got m_tvalid %b s_tready %b, required 0 0", m_tvalid, s_tready);
      end
      vectors++;
      if (in_flight !== 2'd0 || grant_id !== 3'd0 || busy !== 1'b0 || credit_err !== 1'b0) begin
         errs++;
         $display("FAIL reset_state: got if %0d gid %0d busy %b cerr %b, required 0 0 0 0",
                  in_flight, grant_id, busy, credit_err);
      end
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic test_single_source();
      test_reset();
      send_pkt(2, 3, 32'hC700_0100);
      expect_pkt(2, 3, 32'hC700_0100);
      step();
      vectors++;
      if (busy !== 1'b1 || grant_id !== 3'd2 || in_flight !== 2'd1 || exp_q.size() != 3) begin
         errs++;
         $display("FAIL single_grant: got busy %b gid %0d if %0d pend %0d, required 1 2 1 3",
                  busy, grant_id, in_flight, exp_q.size());
      end
      wait_drain(20, 0);
      vectors++;
      if (busy !== 1'b0 || in_flight !== 2'd1) begin
         errs++;
         $display("FAIL single_end: got busy %b if %0d, required 0 1", busy, in_flight);
      end
      man_done = 1'b1; step(); man_done = 1'b0;
      vectors++;
      if (in_flight !== 2'd0 || credit_err !== 1'b0) begin
         errs++;
         $display("FAIL single_credit: got if %0d cerr %b, required 0 0", in_flight, credit_err);
      end
   endtask

   task automatic test_round_robin();
      test_reset();
      auto_done = 1'b1;
      send_pkt(0, 1, 32'hC700_0200); send_pkt(0, 1, 32'hC700_0240);
      send_pkt(1, 1, 32'hC700_0210); send_pkt(2, 1, 32'hC700_0220);
      send_pkt(3, 1, 32'hC700_0230);
      expect_pkt(0, 1, 32'hC700_0200); expect_pkt(1, 1, 32'hC700_0210);
      expect_pkt(2, 1, 32'hC700_0220); expect_pkt(3, 1, 32'hC700_0230);
      expect_pkt(0, 1, 32'hC700_0240);
      wait_drain(60, 0);
      vectors++;
      if (in_flight !== 2'd0 || credit_err !== 1'b0 || grant_id !== 3'd0) begin
         errs++;
         $display("FAIL rr_end: got if %0d cerr %b gid %0d, required 0 0 0",
                  in_flight, credit_err, grant_id);
      end
      auto_done = 1'b0;
   endtask

   task automatic test_credit_limit();
      test_reset();
      send_pkt(0, 1, 32'hC700_0300); send_pkt(1, 1, 32'hC700_0310);
      send_pkt(2, 2, 32'hC700_0320);
      expect_pkt(0, 1, 32'hC700_0300); expect_pkt(1, 1, 32'hC700_0310);
      expect_pkt(2, 2, 32'hC700_0320);
      wait_drain(30, 2);
      repeat (4) step();
      vectors++;
      if (busy !== 1'b0 || in_flight !== 2'd2 || exp_q.size() != 2) begin
         errs++;
         $display("FAIL credit_stall: got busy %b if %0d pend %0d, required 0 2 2",
                  busy, in_flight, exp_q.size());
      end
      man_done = 1'b1; step(); man_done = 1'b0;
      vectors++;
      if (busy !== 1'b0 || in_flight !== 2'd1) begin
         errs++;
         $display("FAIL credit_return: got busy %b if %0d, required 0 1", busy, in_flight);
      end
      step();
      vectors++;
      if (busy !== 1'b1 || in_flight !== 2'd2 || grant_id !== 3'd2) begin
         errs++;
         $display("FAIL credit_readmit: got busy %b if %0d gid %0d, required 1 2 2",
                  busy, in_flight, grant_id);
      end
      wait_drain(20, 0);
      vectors++;
      if (in_flight !== 2'd2) begin
         errs++;
         $display("FAIL credit_hold: got if %0d, required 2", in_flight);
      end
   endtask

   task automatic test_admit_and_complete();
      test_reset();
      send_pkt(0, 1, 32'hC700_0400);
      expect_pkt(0, 1, 32'hC700_0400);
      step(); step();
      send_pkt(1, 1, 32'hC700_0410);
      expect_pkt(1, 1, 32'hC700_0410);
      man_done = 1'b1; step(); man_done = 1'b0;
      vectors++;
      if (in_flight !== 2'd1 || busy !== 1'b1 || grant_id !== 3'd1 || exp_q.size() != 1) begin
         errs++;
         $display("FAIL same_cycle: got if %0d busy %b gid %0d pend %0d, required 1 1 1 1",
                  in_flight, busy, grant_id, exp_q.size());
      end
      wait_drain(20, 0);
   endtask

   task automatic test_credit_err_backpressure();
      test_reset();
      man_done = 1'b1; step(); man_done = 1'b0;
      vectors++;
      if (credit_err !== 1'b1 || in_flight !== 2'd0) begin
         errs++;
         $display("FAIL credit_err: got cerr %b if %0d, required 1 0", credit_err, in_flight);
      end
      send_pkt(3, 5, 32'hC700_0530); send_pkt(1, 3, 32'hC700_0510);
      expect_pkt(1, 3, 32'hC700_0510); expect_pkt(3, 5, 32'hC700_0530);
      rand_rdy = 1'b1;
      wait_drain(400, 0);
      rand_rdy = 1'b0; m_tready = 1'b1; bubble = '0;
      vectors++;
      if (credit_err !== 1'b1 || in_flight !== 2'd2) begin
         errs++;
         $display("FAIL bp_end: got cerr %b if %0d, required 1 2", credit_err, in_flight);
      end
   endtask

   task automatic test_reset_mid_packet();
      test_reset();
      send_pkt(2, 4, 32'hC700_0620);
      expect_pkt(2, 4, 32'hC700_0620);
      step(); step(); step();
      vectors++;
      if (exp_q.size() != 2 || busy !== 1'b1) begin
         errs++;
         $display("FAIL mid_pkt: got pend %0d busy %b, required 2 1", exp_q.size(), busy);
      end
      test_reset();
      send_pkt(2, 1, 32'hC700_0640); send_pkt(0, 1, 32'hC700_0600);
      expect_pkt(0, 1, 32'hC700_0600); expect_pkt(2, 1, 32'hC700_0640);
      step();
      vectors++;
      if (grant_id !== 3'd0 || busy !== 1'b1) begin
         errs++;
         $display("FAIL post_reset_grant: got gid %0d busy %b, required 0 1", grant_id, busy);
      end
      wait_drain(20, 0);
   endtask

   initial begin
      for (int i = 0; i < N; i++) begin src_hd[i] = 0; src_tl[i] = 0; end
      test_single_source();
      test_round_robin();
      test_credit_limit();
      test_admit_and_complete();
      test_credit_err_backpressure();
      test_reset_mid_packet();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
      $fatal(1);
   end
endmodule
